// File: rtl/aer_spike_collector_if.sv
// Spike stream, readback and vote-result bundle for aer_spike_collector.
// The master side drives the spike stream; the slave side reports results.
interface aer_spike_collector_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8,
  parameter int STEP_W = 8
);
  logic              start;
  logic [STEP_W-1:0] num_steps;
  logic              spk;
  logic [ADDR_W-1:0] spk_addr;
  logic              step_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_count;
  logic              busy;
  logic              result_valid;
  logic [ADDR_W-1:0] winner;
  logic [CNT_W-1:0]  winner_count;
  logic              addr_err;

  modport master (
    output start, num_steps, spk, spk_addr, step_done, rd_addr,
    input  rd_count, busy, result_valid, winner, winner_count, addr_err
  );

  modport slave (
    input  start, num_steps, spk, spk_addr, step_done, rd_addr,
    output rd_count, busy, result_valid, winner, winner_count, addr_err
  );
endinterface

// File: rtl/aer_spike_collector.sv
// Per-neuron spike counting over a timestep window, then an argmax scan
// that reports the winning neuron with a one-cycle strobe.
module aer_spike_collector #(
  parameter int NUM_NEURONS = 40,
  parameter int ADDR_W      = 6,
  parameter int CNT_W       = 8,
  parameter int STEP_W      = 8
) (
  input logic              clk,
  input logic              rst,
  aer_spike_collector_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    SCAN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   NN   = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  cnt [NUM_NEURONS];
  logic [ADDR_W-1:0] idx;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] steps;
  logic [ADDR_W-1:0] best_idx;
  logic [CNT_W-1:0]  best_cnt;
  logic [ADDR_W-1:0] win_q;
  logic [CNT_W-1:0]  win_cnt_q;
  logic              err_q;
  logic [CNT_W-1:0]  rd_q;

  logic              start_acc;
  logic              idx_last;
  logic              last_step;
  logic              spk_ok;
  logic              rd_ok;
  logic [CNT_W-1:0]  cand;
  logic              cand_wins;
  logic [ADDR_W-1:0] nx_best_idx;
  logic [CNT_W-1:0]  nx_best_cnt;

  assign start_acc = (state == IDLE) && bus.start;
  assign idx_last  = (idx == LAST);
  assign last_step = bus.step_done &&
                     (step_cnt == steps - STEP_W'(1));
  assign spk_ok    = ({1'b0, bus.spk_addr} < NN);
  assign rd_ok     = ({1'b0, bus.rd_addr} < NN);

  // Index 0 seeds the running best; later ties keep the lower index.
  assign cand        = cnt[idx];
  assign cand_wins   = (idx == '0) || (cand > best_cnt);
  assign nx_best_idx = cand_wins ? idx  : best_idx;
  assign nx_best_cnt = cand_wins ? cand : best_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = CLEAR;
      CLEAR:   if (idx_last)  state_nx = COLLECT;
      COLLECT: if (last_step) state_nx = SCAN;
      SCAN:    if (idx_last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if ((state == CLEAR || state == SCAN) && !idx_last) begin
      idx <= idx + ADDR_W'(1);
    end else begin
      idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (state == CLEAR && idx == ADDR_W'(i)) begin
        cnt[i] <= '0;
      end else if (state == COLLECT && bus.spk &&
                   bus.spk_addr == ADDR_W'(i) && cnt[i] != CMAX) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // A zero window length is stored as one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      steps <= '0;
    end else if (start_acc) begin
      steps <= (bus.num_steps == '0) ? STEP_W'(1) : bus.num_steps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (state == CLEAR) begin
      step_cnt <= '0;
    end else if (state == COLLECT && bus.step_done) begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (state == COLLECT && bus.spk && !spk_ok) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx  <= '0;
      best_cnt  <= '0;
      win_q     <= '0;
      win_cnt_q <= '0;
    end else if (state == SCAN) begin
      best_idx <= nx_best_idx;
      best_cnt <= nx_best_cnt;
      if (idx_last) begin
        win_q     <= nx_best_idx;
        win_cnt_q <= nx_best_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_q <= '0;
    else if (rd_ok) rd_q <= cnt[bus.rd_addr];
    else            rd_q <= '0;
  end

  assign bus.rd_count     = rd_q;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.winner       = win_q;
  assign bus.winner_count = win_cnt_q;
  assign bus.addr_err     = err_q;

endmodule

// File: tb/tb_aer_spike_collector.sv
// Directed bench for aer_spike_collector: expected votes are queued by the
// stimulus and checked by an independent monitor on each result strobe.
module tb_aer_spike_collector;

  localparam int N = 40;

  typedef struct {
    logic [5:0] w;
    logic [7:0] c;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  aer_spike_collector_if #(.ADDR_W(6), .CNT_W(8), .STEP_W(8)) bus ();

  aer_spike_collector #(
    .NUM_NEURONS(N),
    .ADDR_W(6),
    .CNT_W(8),
    .STEP_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("winner", 32'(bus.winner), 32'(e.w));
        chk("winner_count", 32'(bus.winner_count), 32'(e.c));
        chk("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start_win(logic [7:0] n);
    bus.start = 1'b1;
    bus.num_steps = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic spike(logic [5:0] a);
    bus.spk = 1'b1;
    bus.spk_addr = a;
    @(negedge clk);
    bus.spk = 1'b0;
  endtask

  task automatic spikes(logic [5:0] a, int n);
    for (int i = 0; i < n; i++) spike(a);
  endtask

  task automatic step(bit fin, logic [5:0] w = 0, logic [7:0] c = 0,
                      bit with_spk = 0, logic [5:0] a = 0);
    bus.step_done = 1'b1;
    if (with_spk) begin
      bus.spk = 1'b1;
      bus.spk_addr = a;
    end
    if (fin) q.push_back('{w, c, cyc + 1 + N});
    @(negedge clk);
    bus.step_done = 1'b0;
    bus.spk = 1'b0;
  endtask

  task automatic rd(logic [5:0] a, logic [7:0] exp, string name);
    bus.rd_addr = a;
    @(negedge clk);
    chk(name, 32'(bus.rd_count), 32'(exp));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.spk = 1'b0;
    bus.spk_addr = '0;
    bus.step_done = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_winner", 32'(bus.winner), 0);
    chk("rst_winner_count", 32'(bus.winner_count), 0);
    chk("rst_addr_err", 32'(bus.addr_err), 0);
    chk("rst_rd_count", 32'(bus.rd_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic vote
    start_win(3);
    repeat (N) @(negedge clk);
    chk("busy_collect", 32'(bus.busy), 1);
    spikes(5, 2);
    spikes(12, 3);
    step(0);
    spikes(5, 2);
    spikes(12, 2);
    spike(30);
    step(0);
    spikes(12, 2);
    spike(30);
    step(1, 12, 7);
    repeat (N + 4) @(negedge clk);
    chk("busy_idle", 32'(bus.busy), 0);
    rd(5, 4, "rd_addr5");
    rd(12, 7, "rd_addr12");
    rd(30, 2, "rd_addr30");
    rd(45, 0, "rd_out_of_range");

    // tie resolves to lower index
    start_win(2);
    repeat (N) @(negedge clk);
    spikes(9, 3);
    step(0);
    spikes(3, 3);
    step(1, 3, 3);
    repeat (N + 4) @(negedge clk);

    // no spikes
    start_win(1);
    repeat (N) @(negedge clk);
    step(1, 0, 0);
    repeat (N + 4) @(negedge clk);

    // saturation and address error
    start_win(1);
    repeat (N) @(negedge clk);
    spikes(1, 300);
    chk("addr_err_clean", 32'(bus.addr_err), 0);
    spike(50);
    chk("addr_err_set", 32'(bus.addr_err), 1);
    step(1, 1, 255);
    repeat (N + 4) @(negedge clk);
    chk("addr_err_sticky", 32'(bus.addr_err), 1);
    rd(1, 255, "rd_saturated");
    rd(2, 0, "rd_neighbour");

    // clear/scan spikes dropped, final-step spike counted, start ignored
    start_win(2);
    chk("addr_err_cleared", 32'(bus.addr_err), 0);
    spikes(7, 2);
    repeat (N - 2) @(negedge clk);
    bus.start = 1'b1;
    bus.num_steps = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    step(0);
    step(1, 7, 1, 1, 7);
    spikes(7, 3);
    repeat (N + 1) @(negedge clk);
    rd(7, 1, "rd_edge_addr7");

    // reset mid-window
    start_win(3);
    repeat (N) @(negedge clk);
    spikes(4, 5);
    step(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy_after_rst", 32'(bus.busy), 0);
    repeat (N + 10) @(negedge clk);
    start_win(1);
    repeat (N) @(negedge clk);
    spikes(4, 2);
    spike(6);
    step(1, 4, 2);
    repeat (N + 4) @(negedge clk);

    // zero window length acts as one
    start_win(0);
    repeat (N) @(negedge clk);
    spike(11);
    step(1, 11, 1);
    repeat (N + 4) @(negedge clk);

    chk("pending_results", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aer_spike_collector.md
Name: aer_spike_collector

Overview:
- Receiving end of the first-layer spike AER stream: samples the (spk, neuron address) pair emitted per neuron evaluation and the per-timestep completion strobe from the layer controller.
- Accumulates a saturating spike count per output neuron over a programmable window of timesteps, then scans the counts and reports the winning neuron (class vote) with a one-cycle result strobe.
- Sits between the first-layer neuron/controller datapath and the ensemble voting logic.

Parameters:
- NUM_NEURONS, 40, number of output neurons tracked (1..64)
- ADDR_W, 6, width of spike address
- CNT_W, 8, width of each per-neuron spike counter
- STEP_W, 8, width of timestep counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins clear and collection window (accepted in IDLE only)
- num_steps  in  STEP_W  window length in timesteps, sampled on accepted start; 0 treated as 1
- spk  in  1  spike event valid this cycle
- spk_addr  in  ADDR_W  address of the spiking neuron
- step_done  in  1  pulse; current timestep finished
- rd_addr  in  ADDR_W  count readback address
- rd_count  out  CNT_W  registered count at rd_addr, 1-cycle latency
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  one-cycle pulse, winner fields valid
- winner  out  ADDR_W  index of neuron with highest count
- winner_count  out  CNT_W  count of winning neuron
- addr_err  out  1  sticky: spike received with spk_addr >= NUM_NEURONS

Behaviour:
- Reset: state IDLE; all outputs 0; all counters, step counter and latched num_steps cleared. Reset in any state aborts the operation with no result_valid.
- States: IDLE, CLEAR, COLLECT, SCAN, DONE.
- IDLE: start=1 -> latch num_steps, clear addr_err, go to CLEAR. spk/step_done ignored.
- CLEAR: writes 0 to one counter per cycle, index 0..NUM_NEURONS-1 (NUM_NEURONS cycles), then COLLECT with step counter = 0. Spikes during CLEAR are dropped.
- COLLECT: spk=1 and spk_addr < NUM_NEURONS -> counter[spk_addr] += 1, saturating at 2^CNT_W-1. spk=1 with spk_addr out of range -> no count, addr_err=1 (sticky until next accepted start). step_done=1 -> step counter += 1; if step counter == latched num_steps-1 on that edge, next state SCAN. A spike in the same cycle as the final step_done is counted.
- SCAN: one index per cycle, 0..NUM_NEURONS-1; a candidate replaces the running best only if its count is strictly greater (ties resolve to the lowest index). Initial best = index 0. Lasts NUM_NEURONS cycles; spk/step_done ignored.
- DONE: result_valid=1 for exactly one cycle; winner/winner_count hold their value until the next accepted start; next state IDLE.
- Latency: final step_done sampled at edge k -> SCAN covers cycles k+1..k+NUM_NEURONS -> result_valid high in cycle k+NUM_NEURONS+1.
- start while busy: ignored, no effect on the window.
- All counts zero: winner=0, winner_count=0.
- rd_count: counter[rd_addr] registered each cycle in every state; out-of-range rd_addr returns 0.
- busy deasserts in the same cycle the state returns to IDLE (the cycle after result_valid).

Test Plan:
- Basic vote: NUM_NEURONS=40, num_steps=3; spikes to addr 5 x4, addr 12 x7, addr 30 x2 spread over 3 step_done pulses -> result_valid 41 cycles after 3rd step_done, winner=12, winner_count=7; rd_addr=5 gives rd_count=4.
- Tie and zero: addr 9 x3 and addr 3 x3 -> winner=3, winner_count=3; a run with no spikes -> winner=0, winner_count=0.
- Saturation and error: 300 spikes to addr 1 (CNT_W=8) -> winner_count=255; spk_addr=50 once -> addr_err=1 and no counter changes; next start clears addr_err.
- Edge timing: spike to addr 7 in the same cycle as the final step_done is counted; spikes during CLEAR and SCAN are not; start pulsed mid-COLLECT is ignored.
- Reset mid-COLLECT: rst at step 1 of 3 -> busy=0 and no result_valid; a new window after reset shows only the new spikes (all counts start at 0).
- num_steps=0: behaves as 1; result follows the first step_done.
